alu_serial_seq: RTL
===================

# alu_serial_seq

Bit-serial 16-bit ALU sequencer that drives one external 1-bit ALU slice, LSB first, one bit per clock, and reassembles the word result and flags. It is the control-and-operand side of the slice interface: it registers the operands and control, feeds the slice `A`/`B`/`CIN`/`AInvert`/`BInvert`/`Less`/`Op` each cycle, and captures `Result`/`CarryOut` back. It is used in the area-reduced CPU variant, where one slice replaces the 16-slice ripple ALU.

## Interface
- `WIDTH`, 16, operand width; also the number of serial steps.
- `Clock` in 1: the single clock; all state updates on the rising edge.
- `ResetN` in 1: synchronous, active-low reset.
- `Start` in 1: request an operation; sampled only in IDLE.
- `OpA` in WIDTH: operand A, captured when Start is accepted.
- `OpB` in WIDTH: operand B, captured when Start is accepted.
- `ALUCtrl` in 5: `{AInvert, BInvert, Op[2:0]}`, captured when Start is accepted.
- `SliceA`, `SliceB`, `SliceCin`, `SliceAInvert`, `SliceBInvert`, `SliceLess` out 1 each: drives to the slice.
- `SliceOp` out 3: slice operation select.
- `SliceResult`, `SliceCarryOut` in 1 each: combinational returns from the slice in the same cycle.
- `Result` out WIDTH: word result; held until the next accepted Start.
- `CarryOut`, `Overflow`, `Zero` out 1 each: flags, held with Result.
- `Busy` out 1: high while serial steps run.
- `Done` out 1: one-cycle pulse when Result and flags are valid.

## Operation
- Op encoding:
  - 000 AND.
  - 001 SLT (signed set-less-than).
  - 010 OR.
  - 011 XOR.
  - 100 ADD, or SUB when BInvert=1.
  - 101–111 illegal.
- AInvert and BInvert apply to every op, so AND with both set gives NOR.
- FSM states:
  - IDLE: Start=1 captures operands and control, clears the bit counter, loads the carry register, then goes to SHIFT. Start=0 stays in IDLE.
  - SHIFT: step i (0..WIDTH-1) drives bit i to the slice and captures `SliceResult` into `Result[i]` and `SliceCarryOut` into the carry register. The counter increments. After step WIDTH-1 the state goes to DONE.
  - DONE: Done=1 for one cycle, then unconditionally back to IDLE.
- Slice drive in SHIFT:
  - `SliceA` = `OpA[i]`, `SliceB` = `OpB[i]`, `SliceCin` = carry register, `SliceLess` = 0.
  - `SliceAInvert`/`SliceBInvert` come from the captured ALUCtrl.
- Slice drive in IDLE and DONE: all slice outputs 0.
- Initial carry: BInvert for ADD/SUB, 1 for SLT, 0 for logic ops.
- SLT:
  - Drives `SliceOp`=100 with `SliceBInvert`=1.
  - At the final step, Result is loaded with `{WIDTH-1 zeros, MSB sum XOR overflow}` (correct signed compare).
- Illegal op: `SliceOp` = 000; Result is forced to 0, all flags 0, and Done still pulses.
- Flags, updated at the final SHIFT edge:
  - CarryOut = final slice carry for ADD/SUB/SLT, else 0.
  - Overflow = (carry into MSB) XOR (carry out of MSB), ADD/SUB/SLT only, else 0.
  - Zero = (final Result == 0).
- Start is ignored in SHIFT and DONE; no queuing.

## Timing
- Reset (ResetN=0 at an edge): state IDLE; Result=0; CarryOut, Overflow, Zero, Busy, Done all 0; slice drives 0. This applies mid-operation too; the in-flight op is discarded and Done does not pulse.
- Start accepted at edge E0:
  - Busy=1 from after E0 through after E0+WIDTH-1.
  - Result bits and flags are final after edge E0+WIDTH.
  - Done=1 in the cycle after E0+WIDTH; Busy=0 in that cycle.
  - Back in IDLE after E0+WIDTH+1; the earliest next Start is sampled at that edge.
- Fixed latency of WIDTH+1 cycles, Start to Done, for every op including SLT and illegal ops.
- Result/flags are stable from Done until the edge after the next accepted Start. Partial bits may be visible during SHIFT.

## Test plan
- ADD: 0x7FFF + 0x0001 -> Result=0x8000, CarryOut=0, Overflow=1, Zero=0. Done exactly 17 cycles after the Start edge.
- SUB (BInvert=1, Op=100): 0x0005 − 0x0005 -> Result=0x0000, Zero=1, CarryOut=1, Overflow=0.
- SLT:
  - 0xFFFD vs 0x0002 -> Result=0x0001.
  - 0x7FFF vs 0x8000 -> Result=0x0000 (overflow case).
- Logic:
  - XOR 0xA5A5 ^ 0xFFFF -> 0x5A5A.
  - NOR (AInvert=BInvert=1, Op=000) 0x00F0, 0x0F00 -> 0xF00F.
  - In both cases CarryOut=Overflow=0.
- Start pulsed at SHIFT step 5 with different operands -> ignored; the original result is produced and Done pulses once.
- ResetN=0 at step 8 of an ADD -> all outputs 0 the next cycle, no Done pulse. A new Start after release completes normally.

Source files
------------

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial 16-bit ALU sequencer driving one external 1-bit ALU slice
module alu_serial_seq #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [4:0]       ALUCtrl,
    output logic             SliceA,
    output logic             SliceB,
    output logic             SliceCin,
    output logic             SliceAInvert,
    output logic             SliceBInvert,
    output logic             SliceLess,
    output logic [2:0]       SliceOp,
    input  logic             SliceResult,
    input  logic             SliceCarryOut,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_SLT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic             ainv_r;
    logic             binv_r;
    logic [2:0]       op_r;
    logic             carry_r;

    logic             is_slt;
    logic             is_arith;
    logic             is_illegal;
    logic             last;
    logic             ovf_next;
    logic             init_carry;
    logic [WIDTH-1:0] res_next;

    assign is_slt     = (op_r == OP_SLT);
    assign is_arith   = (op_r == OP_ADD) || is_slt;
    assign is_illegal = (op_r > OP_ADD);
    assign last       = (cnt == LAST);
    // carry_r holds the carry into the current bit, so at the MSB this is cin XOR cout
    assign ovf_next   = carry_r ^ SliceCarryOut;

    assign init_carry = (ALUCtrl[2:0] == OP_ADD) ? ALUCtrl[3] :
                        (ALUCtrl[2:0] == OP_SLT) ? 1'b1 : 1'b0;

    assign Busy = (state == S_SHIFT);
    assign Done = (state == S_DONE);

    always_comb begin
        SliceA       = 1'b0;
        SliceB       = 1'b0;
        SliceCin     = 1'b0;
        SliceAInvert = 1'b0;
        SliceBInvert = 1'b0;
        SliceLess    = 1'b0;
        SliceOp      = 3'b000;
        if (state == S_SHIFT) begin
            SliceA       = opa_r[cnt];
            SliceB       = opb_r[cnt];
            SliceCin     = carry_r;
            SliceAInvert = ainv_r;
            SliceBInvert = is_slt ? 1'b1 : binv_r;
            SliceOp      = is_slt ? OP_ADD : (is_illegal ? OP_AND : op_r);
        end
    end

    // SLT runs as a subtract and replaces the word with the signed-compare bit at the end
    always_comb begin
        res_next      = Result;
        res_next[cnt] = is_illegal ? 1'b0 : SliceResult;
        if (is_slt && last) begin
            res_next = {{(WIDTH-1){1'b0}}, SliceResult ^ ovf_next};
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state    <= S_IDLE;
            cnt      <= '0;
            opa_r    <= '0;
            opb_r    <= '0;
            ainv_r   <= 1'b0;
            binv_r   <= 1'b0;
            op_r     <= 3'b000;
            carry_r  <= 1'b0;
            Result   <= '0;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        opa_r   <= OpA;
                        opb_r   <= OpB;
                        ainv_r  <= ALUCtrl[4];
                        binv_r  <= ALUCtrl[3];
                        op_r    <= ALUCtrl[2:0];
                        cnt     <= '0;
                        carry_r <= init_carry;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    Result  <= res_next;
                    carry_r <= SliceCarryOut;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        CarryOut <= is_arith ? SliceCarryOut : 1'b0;
                        Overflow <= is_arith ? ovf_next : 1'b0;
                        Zero     <= !is_illegal && (res_next == '0);
                        state    <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
